// File: rtl/lfsr_prbs_generator.sv
// Parameterised PRBS generator: an LFSR advanced OUTPUT_WIDTH steps per enabled clock,
// with the generated bits registered on data_out (optionally inverted and bit-reversed).
module lfsr_prbs_generator #(
    parameter int unsigned              LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_POLY    = 31'h10000001,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_INIT    = {LFSR_WIDTH{1'b1}},
    parameter string                    LFSR_CONFIG  = "FIBONACCI",
    parameter bit                       REVERSE      = 1'b0,
    parameter bit                       INVERT       = 1'b1,
    parameter int unsigned              OUTPUT_WIDTH = 64,
    parameter string                    STYLE        = "AUTO"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic [OUTPUT_WIDTH-1:0] data_out
);

    localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");
    localparam bit USE_LOOP  = (STYLE == "LOOP");
    // The x^0 term is implicit in both topologies, so bit 0 of the polynomial is ignored.
    localparam logic [LFSR_WIDTH-1:0] TAP_MASK = LFSR_POLY & ~{{(LFSR_WIDTH-1){1'b0}}, 1'b1};

    logic [LFSR_WIDTH-1:0]   state_q;
    logic [LFSR_WIDTH-1:0]   state_nxt;
    logic [OUTPUT_WIDTH-1:0] word_nxt;
    logic [LFSR_WIDTH-1:0]   work;
    logic [OUTPUT_WIDTH-1:0] gen;
    logic                    fb;

    function automatic logic [LFSR_WIDTH-1:0] mirror_state(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LFSR_WIDTH; i++) begin
            r[i] = v[LFSR_WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [OUTPUT_WIDTH-1:0] mirror_word(input logic [OUTPUT_WIDTH-1:0] v);
        logic [OUTPUT_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
            r[i] = v[OUTPUT_WIDTH-1-i];
        end
        return r;
    endfunction

    // REVERSE is handled by mirroring into a canonical MSB-first frame, stepping there,
    // and mirroring back; the unrolled loop below collapses into a pure XOR matrix.
    always_comb begin
        work = REVERSE ? mirror_state(state_q) : state_q;
        gen  = '0;
        fb   = 1'b0;
        for (int unsigned i = 0; i < OUTPUT_WIDTH; i++) begin
            if (IS_GALOIS) begin
                fb   = work[LFSR_WIDTH-1];
                work = {work[LFSR_WIDTH-2:0], fb} ^ ({LFSR_WIDTH{fb}} & TAP_MASK);
            end else begin
                if (USE_LOOP) begin
                    fb = work[LFSR_WIDTH-1];
                    for (int unsigned j = 1; j < LFSR_WIDTH; j++) begin
                        if (TAP_MASK[j]) begin
                            fb = fb ^ work[j-1];
                        end
                    end
                end else begin
                    fb = work[LFSR_WIDTH-1] ^ (^(work[LFSR_WIDTH-2:0] & TAP_MASK[LFSR_WIDTH-1:1]));
                end
                work = {work[LFSR_WIDTH-2:0], fb};
            end
            gen[OUTPUT_WIDTH-1-i] = fb;
        end
        state_nxt = REVERSE ? mirror_state(work) : work;
        word_nxt  = REVERSE ? mirror_word(gen) : gen;
        if (INVERT) begin
            word_nxt = ~word_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LFSR_INIT;
            data_out <= '0;
        end else if (enable) begin
            state_q  <= state_nxt;
            data_out <= word_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_generator.sv
// Scoreboard bench for lfsr_prbs_generator: three configurations driven by one random enable,
// each checked against a software PRBS model (parity-of-taps / multiply-by-x mod p).
module tb_lfsr_prbs_generator;

    localparam longint unsigned MASK     = 64'h7FFF_FFFF;
    localparam longint unsigned FIB_TAPS = 64'h4800_0000;
    localparam longint unsigned GAL_POLY = 64'h1000_0001;
    localparam logic [63:0]     FIRST_WORD = 64'hFFFF_FFF1_FFFF_FF03;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] d0;
    logic [30:0] d1;
    logic [7:0]  d2;

    lfsr_prbs_generator dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_out(d0)
    );

    lfsr_prbs_generator #(
        .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("GALOIS"),
        .REVERSE(1'b1), .INVERT(1'b0), .OUTPUT_WIDTH(31), .STYLE("LOOP")
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_out(d1)
    );

    lfsr_prbs_generator #(
        .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("FIBONACCI"),
        .REVERSE(1'b0), .INVERT(1'b1), .OUTPUT_WIDTH(8), .STYLE("LOOP")
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_out(d2)
    );

    always #5 clk = ~clk;

    longint unsigned ms [3];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [63:0] last0 = '0;
    logic [63:0] last1 = '0;
    logic [63:0] last2 = '0;
    int vectors = 0;
    int miscompares = 0;
    bit en_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) ms[i] = MASK;
    endfunction

    // Fibonacci: new bit = parity of tapped history bits. Galois: state = x*state mod p.
    function automatic bit model_bit(input int d);
        bit b;
        if (d == 1) begin
            b = ms[d][30];
            ms[d] = ((ms[d] << 1) ^ (b ? GAL_POLY : 64'd0)) & MASK;
        end else begin
            b = ^(ms[d] & FIB_TAPS);
            ms[d] = ((ms[d] << 1) | {63'd0, b}) & MASK;
        end
        return b;
    endfunction

    function automatic logic [63:0] gen_word(input int d, input int width, input bit rev, input bit inv);
        logic [63:0] wd;
        bit b;
        wd = '0;
        for (int i = 0; i < width; i++) begin
            b = model_bit(d);
            if (rev) wd[i] = b;
            else     wd[width-1-i] = b;
        end
        if (inv) begin
            wd = ~wd;
            if (width < 64) wd = wd & ((64'd1 << width) - 64'd1);
        end
        return wd;
    endfunction

    task automatic cycle(input bit en);
        @(posedge clk);
        #2;
        enable = en;
        if (en) begin
            q0.push_back(gen_word(0, 64, 1'b0, 1'b1));
            q1.push_back(gen_word(1, 31, 1'b1, 1'b0));
            q2.push_back(gen_word(2, 8, 1'b0, 1'b1));
        end
    endtask

    always @(posedge clk) en_seen <= enable & rst_n;

    // Monitor: pops one expected word per DUT after every enabled edge, else checks hold.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_d0", d0, '0);
                check("reset_d1", {33'd0, d1}, '0);
                check("reset_d2", {56'd0, d2}, '0);
                last0 = '0; last1 = '0; last2 = '0;
            end else if (en_seen) begin
                if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_underflow: got output with empty queue, expected pending word at %0t", $time);
                end else begin
                    e = q0.pop_front(); check("word_d0", d0, e); last0 = e;
                    e = q1.pop_front(); check("word_d1_galois_rev", {33'd0, d1}, e); last1 = e;
                    e = q2.pop_front(); check("word_d2_w8", {56'd0, d2}, e); last2 = e;
                end
            end else begin
                check("hold_d0", d0, last0);
                check("hold_d1", {33'd0, d1}, last1);
                check("hold_d2", {56'd0, d2}, last2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        repeat (10) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        check("first_word", d0, FIRST_WORD);

        repeat (1000) cycle(1'b1);
        repeat (600) cycle($urandom_range(0, 2) != 0);

        cycle(1'b0);
        cycle(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_d0", d0, '0);
        check("async_reset_d2", {56'd0, d2}, '0);
        check("queue_drained", 64'(q0.size()), '0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(1'b1);
        cycle(1'b0);
        check("first_word_after_reset", d0, FIRST_WORD);

        repeat (300) cycle($urandom_range(0, 3) != 0);
        cycle(1'b0);
        cycle(1'b0);
        @(posedge clk);
        check("queue_empty_end", 64'(q0.size() + q1.size() + q2.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
